// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive-side byte FIFO with rdy/rdy_clr handshake and overrun flag
//
// Captures each byte presented by the UART (uart_rdy/uart_dout), acknowledges it
// with a one-cycle uart_rdy_clr pulse and buffers it in a DEPTH-entry FIFO that
// the consumer drains through a first-word-fall-through read port.
//
// Ports:
//   clk           single clock, shared with the UART
//   rst           synchronous active-high reset
//   uart_rdy      UART byte-available
//   uart_dout     UART received byte
//   uart_rdy_clr  one-cycle acknowledge pulse back to the UART
//   rd_en         consumer pop request
//   rd_data       head-of-FIFO byte, valid while empty=0
//   empty, full   occupancy flags
//   count         bytes stored, 0..DEPTH
//   overrun       sticky: a received byte was dropped because the FIFO was full
//   ovr_clr       clears overrun (a new overrun in the same cycle wins)

module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          uart_rdy,
   input  logic [7:0]    uart_dout,
   output logic          uart_rdy_clr,
   input  logic          rd_en,
   output logic [7:0]    rd_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overrun,
   input  logic          ovr_clr
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CLR  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   rdy_clr_nxt;
   logic   capture;

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   logic push, pop, drop;

   // Flags come straight from the registered count.
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   // Full/empty are evaluated before this cycle's pop, so a push into a full
   // FIFO is dropped even if a pop happens on the same edge.
   assign push = capture && !full;
   assign drop = capture && full;
   assign pop  = rd_en && !empty;

   assign rd_data = mem[rd_ptr];

   always_comb begin
      state_nxt   = state;
      rdy_clr_nxt = 1'b0;
      capture     = 1'b0;
      case (state)
         S_IDLE: begin
            if (uart_rdy) begin
               capture     = 1'b1;
               rdy_clr_nxt = 1'b1;
               state_nxt   = S_CLR;
            end
         end
         S_CLR: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // Hold off until the UART has actually dropped rdy, so a late
            // rdy deassertion never re-captures the same byte.
            if (!uart_rdy) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         uart_rdy_clr <= 1'b0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_nxt;
         uart_rdy_clr <= rdy_clr_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   // Storage carries no reset; stale contents are unreachable once count=0.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wr_ptr] <= uart_dout;
      end
   end

endmodule
